sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Arbiter and protocol converter sharing the core's single AXI3 master port between the IF-stage instruction SRAM-like port (read-only) and the EX-stage data SRAM-like port (read/write). It sits between the pipeline and the top-level AXI interface. It accepts at most one outstanding read and one outstanding write. Data reads have priority over instruction reads, and data reads are held off while a write is in flight.

## Interface
- No parameters. Data width is 32 bits and address width is 32 bits.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req, inst_wr, inst_size[1:0], inst_wstrb[3:0], inst_addr[31:0], inst_wdata[31:0]  in  instruction SRAM-like request
  - inst_wr, inst_wstrb and inst_wdata are ignored.
- inst_addr_ok, inst_data_ok  out  1; inst_rdata  out  32
- data_req, data_wr, data_size[1:0], data_wstrb[3:0], data_addr[31:0], data_wdata[31:0]  in  data SRAM-like request
- data_addr_ok, data_data_ok  out  1; data_rdata  out  32
- arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid  out; arready  in
- rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out
- awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0], awvalid  out; awready  in
- wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  out; wready  in
- bid[3:0], bresp[1:0], bvalid  in; bready  out

## Operation
- **Constant AXI fields:**
  - arlen = awlen = 0
  - arburst = awburst = 2'b01
  - lock, cache and prot = 0
  - wlast = 1
  - awid = wid = 1
  - arsize = awsize = {1'b0, size}
- **Read IDs:** arid = 0 for an instruction read, 1 for a data read.
- **Read FSM (R_IDLE, R_AR, R_R):**
  - In R_IDLE, the bridge selects a read.
  - data_addr_ok = data_req & ~data_wr & W_IDLE.
  - inst_addr_ok = inst_req & ~(data_req & ~data_wr).
  - On either accept, the bridge latches the addr, size and owner, then moves to R_AR.
  - R_AR: arvalid = 1 until arready, then R_R.
  - R_R: rready = 1. On rvalid, the bridge pulses data_ok for the owner selected by rid[0], then returns to R_IDLE.
- **Write FSM (W_IDLE, W_SEND, W_B):**
  - In W_IDLE, data_addr_ok = data_req & data_wr & ~(read FSM ≠ R_IDLE and owner = data).
  - On accept, the bridge latches addr, size, wstrb and wdata, then moves to W_SEND.
  - W_SEND: awvalid and wvalid both rise. Each drops independently on its own handshake. The bridge moves to W_B when both handshakes are done, including the same-cycle case.
  - W_B: bready = 1. On bvalid, the bridge pulses data_data_ok and returns to W_IDLE.
- **Read data path:** inst_rdata = data_rdata = rdata, combinational. Data is valid only when the matching data_ok is high.
- **Response codes:** rresp and bresp are ignored.
- **Hazard rules:**
  - No data read is accepted while a write is outstanding. This enforces RAW ordering.
  - No data write is accepted while a data read is outstanding. This guarantees data_data_ok never needs two pulses in one cycle.
- **Flush:** the bridge never cancels an accepted transaction. Requesters drop unwanted responses themselves.
- **Reset values:**
  - All *_addr_ok, *_data_ok, arvalid, awvalid, wvalid, rready and bready = 0.
  - FSMs are in R_IDLE and W_IDLE.
  - Latched registers = 0.

## Timing
- addr_ok is combinational from req in the same cycle. The request is considered transferred on req & addr_ok.
- arvalid and awvalid/wvalid are registered and rise the cycle after accept.
- **Minimum read latency:** accept in cycle 0, AR handshake in cycle 1, rvalid and data_ok in cycle 2.
- **Minimum write latency:** accept in cycle 0, AW+W handshake in cycle 1, bvalid and data_ok in cycle 2.
- data_ok is combinational with rvalid/bvalid and lasts exactly one cycle per transaction.
- An instruction read and a data write may be in flight concurrently. Their completions in the same cycle go to different ports.
- Synchronous reset mid-transaction returns both FSMs to idle in the next cycle. The AXI slave is reset by the same resetn.

## Structure
- Shared package cpu_bus_pkg holds:
  - read and write state enums
  - ID constants: ID_INST = 4'd0, ID_DATA = 4'd1
  - burst, len and cache constants
- One sub-module is natural: axi_write_ch. It holds the W_SEND/W_B FSM with the independent AW and W valid drop logic.
- The read FSM and arbitration stay in the top module.

## Test plan
- inst_req at 0x1C000000 alone, arready = 1, rvalid 1 cycle later with rdata = 0x02800C0C → inst_addr_ok in cycle 0, arid = 0 in cycle 1, inst_data_ok and rdata = 0x02800C0C in cycle 2.
- inst_req and data read requested in the same cycle → data_addr_ok = 1 and inst_addr_ok = 0. arid = 1 is issued first. The instruction read is accepted the cycle after R_R completes.
- Data write to 0x100 with wstrb = 4'b0100 and size = 0, with awready one cycle before wready → awvalid drops first, wvalid holds. bready rises after both handshakes. data_data_ok pulses on bvalid.
- Write outstanding (bvalid delayed 5 cycles) while a data read requests 0x100 → data_addr_ok stays 0 until the cycle after bvalid. The read then returns the newly written value.
- Data read outstanding followed by a data write request → the write is not accepted until the read's data_ok. The instruction port meanwhile is unaffected.
- resetn deasserted while in R_AR and W_B → the next cycle shows all valids, readies and ok signals at 0 and both FSMs idle.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared bus types for the core's SRAM-like to AXI3 bridge.
// States, AXI ID values and fixed transfer attributes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_B    = 2'd2
  } w_state_e;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [3:0] CACHE_NONE = 4'd0;

endpackage

// File: rtl/axi_write_ch.sv
// Single-beat AXI3 write issue: AW and W launched together,
// each dropped on its own handshake, then wait for B.
module axi_write_ch
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  input  logic        awready_i,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        awvalid_o,
  output logic        wvalid_o,
  output logic        bready_o,
  output logic [31:0] awaddr_o,
  output logic [1:0]  awsize_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        idle_o,
  output logic        done_o
);

  w_state_e    w_state_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  // a channel counts as done once its valid has dropped or it fires now
  logic aw_done;
  logic w_done;
  assign aw_done = ~awvalid_q | awready_i;
  assign w_done  = ~wvalid_q | wready_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (start_i) begin
            addr_q    <= addr_i;
            size_q    <= size_i;
            wstrb_q   <= wstrb_i;
            wdata_q   <= wdata_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= W_SEND;
          end
        end
        W_SEND: begin
          if (awready_i) awvalid_q <= 1'b0;
          if (wready_i)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q  <= 1'b1;
            w_state_q <= W_B;
          end
        end
        W_B: begin
          if (bvalid_i) begin
            bready_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign awaddr_o  = addr_q;
  assign awsize_o  = size_q;
  assign wstrb_o   = wstrb_q;
  assign wdata_o   = wdata_q;
  assign idle_o    = (w_state_q == W_IDLE);
  assign done_o    = bready_q & bvalid_i;

endmodule

// File: rtl/sram_axi_bridge.sv
// Shares one AXI3 master between the inst and data SRAM-like ports.
// One read and one write outstanding; data reads win over inst reads.
module sram_axi_bridge
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  r_state_e    r_state_q;
  logic [31:0] r_addr_q;
  logic [1:0]  r_size_q;
  logic        r_own_q;
  logic        arvalid_q;
  logic        rready_q;

  logic        r_idle;
  logic        d_rd;
  logic        w_idle;
  logic        w_done;
  logic        rd_acc;
  logic        if_acc;
  logic        wr_acc;
  logic        r_fire;
  logic [1:0]  aw_size;

  assign r_idle = (r_state_q == R_IDLE);
  assign d_rd   = data_req & ~data_wr;
  assign rd_acc = r_idle & d_rd & w_idle;
  assign if_acc = r_idle & inst_req & ~d_rd;
  // a write may overlap an inst read, but never a data read
  assign wr_acc = w_idle & data_req & data_wr
                & ~(~r_idle & r_own_q);

  assign data_addr_ok = rd_acc | wr_acc;
  assign inst_addr_ok = if_acc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_own_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (rd_acc || if_acc) begin
            r_addr_q  <= rd_acc ? data_addr : inst_addr;
            r_size_q  <= rd_acc ? data_size : inst_size;
            r_own_q   <= rd_acc;
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state_q <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  axi_write_ch u_wch (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (wr_acc),
    .addr_i   (data_addr),
    .size_i   (data_size),
    .wstrb_i  (data_wstrb),
    .wdata_i  (data_wdata),
    .awready_i(awready),
    .wready_i (wready),
    .bvalid_i (bvalid),
    .awvalid_o(awvalid),
    .wvalid_o (wvalid),
    .bready_o (bready),
    .awaddr_o (awaddr),
    .awsize_o (aw_size),
    .wstrb_o  (wstrb),
    .wdata_o  (wdata),
    .idle_o   (w_idle),
    .done_o   (w_done)
  );

  assign r_fire       = rready_q & rvalid;
  assign inst_data_ok = r_fire & ~rid[0];
  assign data_data_ok = (r_fire & rid[0]) | w_done;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = r_own_q ? ID_DATA : ID_INST;
  assign araddr  = r_addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, r_size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = CACHE_NONE;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = ID_DATA;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, aw_size};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = CACHE_NONE;
  assign awprot  = 3'b000;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{inst_wr, inst_wstrb, inst_wdata, rid[3:1],
                       rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the AXI slave side is
// driven by hand cycle by cycle with hand-computed expectations.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next edge; caller then drives inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 0;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    rvalid = 0; awready = 0; wready = 0; bid = 0; bresp = 0;
    bvalid = 0;
  endtask

  task automatic drd(input logic [31:0] a);
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = a;
  endtask

  task automatic dwr(input logic [31:0] a, input logic [1:0] s,
                     input logic [3:0] st, input logic [31:0] d);
    data_req = 1; data_wr = 1; data_size = s; data_addr = a;
    data_wstrb = st; data_wdata = d;
  endtask

  initial begin
    clr();
    resetn = 0;
    step(); step();
    settle();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_dok", 32'(data_data_ok), 0);
    resetn = 1;

    // T1 instruction read, minimum latency
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0000; settle();
    chk("t1_iaok", 32'(inst_addr_ok), 1);
    chk("t1_daok", 32'(data_addr_ok), 0);
    step(); clr(); arready = 1; settle();
    chk("t1_arvalid", 32'(arvalid), 1);
    chk("t1_arid", 32'(arid), 0);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    chk("t1_arsize", 32'(arsize), 2);
    chk("t1_arlen", 32'(arlen), 0);
    chk("t1_arburst", 32'(arburst), 1);
    step(); clr(); rvalid = 1; rid = 0; rdata = 32'h0280_0C0C; settle();
    chk("t1_rready", 32'(rready), 1);
    chk("t1_idok", 32'(inst_data_ok), 1);
    chk("t1_rdata", inst_rdata, 32'h0280_0C0C);
    chk("t1_ddok", 32'(data_data_ok), 0);
    step(); clr(); settle();
    chk("t1_idok_pulse", 32'(inst_data_ok), 0);
    chk("t1_rready_off", 32'(rready), 0);

    // T2 data read wins over a simultaneous inst read
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0004; drd(32'h200); settle();
    chk("t2_daok", 32'(data_addr_ok), 1);
    chk("t2_iaok", 32'(inst_addr_ok), 0);
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0004; arready = 1; settle();
    chk("t2_arid_d", 32'(arid), 1);
    chk("t2_araddr_d", araddr, 32'h200);
    chk("t2_iaok_ar", 32'(inst_addr_ok), 0);
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0004;
    rvalid = 1; rid = 1; rdata = 32'hDEAD_BEEF; settle();
    chk("t2_ddok", 32'(data_data_ok), 1);
    chk("t2_idok", 32'(inst_data_ok), 0);
    chk("t2_drdata", data_rdata, 32'hDEAD_BEEF);
    chk("t2_iaok_r", 32'(inst_addr_ok), 0);
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0004; settle();
    chk("t2_iaok_late", 32'(inst_addr_ok), 1);
    step(); clr(); arready = 1; settle();
    chk("t2_arid_i", 32'(arid), 0);
    chk("t2_araddr_i", araddr, 32'h1C00_0004);
    step(); clr(); rvalid = 1; rid = 0; rdata = 32'h1234_5678; settle();
    chk("t2_idok2", 32'(inst_data_ok), 1);
    step(); clr(); settle();

    // T3 byte write, AW accepted before W
    step(); clr();
    dwr(32'h100, 2'd0, 4'b0100, 32'h00AB_0000); settle();
    chk("t3_daok", 32'(data_addr_ok), 1);
    step(); clr(); awready = 1; settle();
    chk("t3_awvalid", 32'(awvalid), 1);
    chk("t3_wvalid", 32'(wvalid), 1);
    chk("t3_awaddr", awaddr, 32'h100);
    chk("t3_awsize", 32'(awsize), 0);
    chk("t3_wstrb", 32'(wstrb), 32'h4);
    chk("t3_wdata", wdata, 32'h00AB_0000);
    chk("t3_awid", 32'(awid), 1);
    chk("t3_wid", 32'(wid), 1);
    chk("t3_wlast", 32'(wlast), 1);
    step(); clr(); wready = 1; settle();
    chk("t3_awvalid_drop", 32'(awvalid), 0);
    chk("t3_wvalid_hold", 32'(wvalid), 1);
    chk("t3_bready_early", 32'(bready), 0);
    step(); clr(); bvalid = 1; settle();
    chk("t3_bready", 32'(bready), 1);
    chk("t3_wvalid_drop", 32'(wvalid), 0);
    chk("t3_ddok", 32'(data_data_ok), 1);
    step(); clr(); settle();
    chk("t3_bready_off", 32'(bready), 0);
    chk("t3_ddok_pulse", 32'(data_data_ok), 0);

    // T4 read-after-write held off until B completes
    step(); clr();
    dwr(32'h100, 2'd2, 4'hF, 32'h1122_3344); settle();
    chk("t4_wr_aok", 32'(data_addr_ok), 1);
    step(); clr(); awready = 1; wready = 1; settle();
    chk("t4_awvalid", 32'(awvalid), 1);
    chk("t4_wvalid", 32'(wvalid), 1);
    step(); clr(); drd(32'h100); settle();
    chk("t4_bready", 32'(bready), 1);
    chk("t4_hold0", 32'(data_addr_ok), 0);
    for (int i = 0; i < 4; i++) begin
      step(); clr(); drd(32'h100); settle();
      chk("t4_hold", 32'(data_addr_ok), 0);
    end
    step(); clr(); drd(32'h100); bvalid = 1; settle();
    chk("t4_hold_b", 32'(data_addr_ok), 0);
    chk("t4_wok", 32'(data_data_ok), 1);
    step(); clr(); drd(32'h100); settle();
    chk("t4_rd_aok", 32'(data_addr_ok), 1);
    step(); clr(); arready = 1; settle();
    chk("t4_araddr", araddr, 32'h100);
    chk("t4_arid", 32'(arid), 1);
    step(); clr(); rvalid = 1; rid = 1; rdata = 32'h1122_3344; settle();
    chk("t4_rok", 32'(data_data_ok), 1);
    chk("t4_rdata", data_rdata, 32'h1122_3344);

    // T5 write blocked behind data read; inst port still flows
    step(); clr(); drd(32'h300); settle();
    chk("t5_rd_aok", 32'(data_addr_ok), 1);
    step(); clr(); dwr(32'h304, 2'd2, 4'hF, 32'hCAFE_F00D);
    arready = 1; settle();
    chk("t5_wr_blk1", 32'(data_addr_ok), 0);
    step(); clr(); dwr(32'h304, 2'd2, 4'hF, 32'hCAFE_F00D); settle();
    chk("t5_wr_blk2", 32'(data_addr_ok), 0);
    chk("t5_rready", 32'(rready), 1);
    step(); clr(); dwr(32'h304, 2'd2, 4'hF, 32'hCAFE_F00D);
    rvalid = 1; rid = 1; rdata = 32'h5555_AAAA; settle();
    chk("t5_rok", 32'(data_data_ok), 1);
    chk("t5_wr_blk3", 32'(data_addr_ok), 0);
    chk("t5_idok", 32'(inst_data_ok), 0);
    step(); clr(); dwr(32'h304, 2'd2, 4'hF, 32'hCAFE_F00D);
    inst_req = 1; inst_addr = 32'h1C00_0100; settle();
    chk("t5_wr_aok", 32'(data_addr_ok), 1);
    chk("t5_iaok", 32'(inst_addr_ok), 1);
    step(); clr(); arready = 1; awready = 1; wready = 1; settle();
    chk("t5_arid", 32'(arid), 0);
    chk("t5_awaddr", awaddr, 32'h304);
    chk("t5_wdata", wdata, 32'hCAFE_F00D);
    step(); clr(); rvalid = 1; rid = 0; rdata = 32'h0000_0013;
    bvalid = 1; settle();
    chk("t5_both_i", 32'(inst_data_ok), 1);
    chk("t5_both_d", 32'(data_data_ok), 1);
    step(); clr(); settle();

    // T6 reset in the middle of R_AR and W_B
    step(); clr();
    inst_req = 1; inst_addr = 32'h1C00_0200;
    dwr(32'h400, 2'd2, 4'hF, 32'h7777_7777); settle();
    chk("t6_iaok", 32'(inst_addr_ok), 1);
    chk("t6_daok", 32'(data_addr_ok), 1);
    step(); clr(); awready = 1; wready = 1; settle();
    step(); clr(); settle();
    chk("t6_arvalid_pre", 32'(arvalid), 1);
    chk("t6_bready_pre", 32'(bready), 1);
    resetn = 0;
    step(); clr(); settle();
    chk("t6_arvalid", 32'(arvalid), 0);
    chk("t6_bready", 32'(bready), 0);
    chk("t6_awvalid", 32'(awvalid), 0);
    chk("t6_wvalid", 32'(wvalid), 0);
    chk("t6_rready", 32'(rready), 0);
    resetn = 1;
    inst_req = 1; inst_addr = 32'h1C00_0300;
    dwr(32'h500, 2'd2, 4'hF, 32'h1);
    settle();
    chk("t6_r_idle", 32'(inst_addr_ok), 1);
    chk("t6_w_idle", 32'(data_addr_ok), 1);
    step(); clr(); settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
